sys_tick_timer: RTL and testbench

//  Parametrised millisecond system timer with compare channels and interrupt; supersedes the fixed cnt0/cnt1 tick logic.

---
 rtl/sys_tick_timer.sv | 156 +++++++++++++++
 tb/tb_sys_tick_timer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_tick_timer.sv
// Prescaled tick counter with NCH compare channels, sticky pending bits and a maskable level irq.
// Latency: pending set on the tick edge where counter+1 == cmp, irq follows from registers; reads are combinational.
// Backpressure: none, register writes always accepted. Optional auto-rearm via SYS_TICK_TIMER_PERIODIC_EN.
module sys_tick_timer #(
   parameter int CLK_FREQ_HZ = 40000000,
   parameter int TICK_HZ     = 1000,
   parameter int NCH         = 4,
   parameter int CNT_W       = 32
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        sel_i,
   input  logic        wr_i,
   input  logic        rd_i,
   input  logic [3:0]  adr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        tick_o,
   output logic        irq_o
);

   localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
   localparam int PRE_W = $clog2(DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [NCH-1:0]   en_q, en_d, mask_q, mask_d, pend_q, pend_d, match;
   logic [CNT_W-1:0] cmp_q [NCH];
   logic [CNT_W-1:0] cmp_d [NCH];
`ifdef SYS_TICK_TIMER_PERIODIC_EN
   logic [CNT_W-1:0] per_q [NCH];
   logic [CNT_W-1:0] per_d [NCH];
`endif

   logic wr_en, cnt_wr, ctrl_wr, w1c_wr;
   logic unused_rd;

   // Reads never have side effects, so the read strobe is not needed.
   assign unused_rd = rd_i;

   assign wr_en   = sel_i & wr_i;
   assign cnt_wr  = wr_en && (adr_i == 4'd0);
   assign ctrl_wr = wr_en && (adr_i == 4'd1);
   assign w1c_wr  = wr_en && (adr_i == 4'd2);

   // Tick is decoded from the prescaler register so it drops as soon as reset hits.
   assign tick_o  = (pre_q == PRE_LAST);
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign irq_o   = |(pend_q & mask_q);

   // A channel hits when the increment about to happen lands on its compare value; a counter write suppresses it.
   always_comb begin
      match = '0;
      for (int i = 0; i < NCH; i++) begin
         match[i] = tick_o && !cnt_wr && en_q[i] && (cnt_inc == cmp_q[i]);
      end
   end

   // Next-state for prescaler, counter, control, pending and compare registers.
   always_comb begin
      pre_d  = tick_o ? '0 : pre_q + PRE_W'(1);
      cnt_d  = tick_o ? cnt_inc : cnt_q;
      if (cnt_wr) begin
         pre_d = '0;
         cnt_d = wdata_i[CNT_W-1:0];
      end
      en_d   = en_q;
      mask_d = mask_q;
      if (ctrl_wr) begin
         en_d   = wdata_i[NCH-1:0];
         mask_d = wdata_i[8 +: NCH];
      end
      // Clear first, then set, so a same-cycle match survives the W1C.
      pend_d = pend_q;
      if (w1c_wr) begin
         pend_d = pend_d & ~wdata_i[NCH-1:0];
      end
      pend_d = pend_d | match;
      for (int i = 0; i < NCH; i++) begin
         cmp_d[i] = cmp_q[i];
`ifdef SYS_TICK_TIMER_PERIODIC_EN
         per_d[i] = per_q[i];
         if (wr_en && (adr_i == 4'(8 + i))) begin
            per_d[i] = wdata_i[CNT_W-1:0];
         end
         if (match[i] && (per_q[i] != '0)) begin
            cmp_d[i] = cmp_q[i] + per_q[i];
         end
`endif
         if (wr_en && (adr_i == 4'(4 + i))) begin
            cmp_d[i] = wdata_i[CNT_W-1:0];
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pre_q  <= '0;
         cnt_q  <= '0;
         en_q   <= '0;
         mask_q <= '0;
         pend_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            cmp_q[i] <= '0;
`ifdef SYS_TICK_TIMER_PERIODIC_EN
            per_q[i] <= '0;
`endif
         end
      end else begin
         pre_q  <= pre_d;
         cnt_q  <= cnt_d;
         en_q   <= en_d;
         mask_q <= mask_d;
         pend_q <= pend_d;
         for (int i = 0; i < NCH; i++) begin
            cmp_q[i] <= cmp_d[i];
`ifdef SYS_TICK_TIMER_PERIODIC_EN
            per_q[i] <= per_d[i];
`endif
         end
      end
   end

   // Read mux, zero when not selected; unmapped addresses read zero.
   always_comb begin
      rdata_o = '0;
      if (sel_i) begin
         if (adr_i == 4'd0) begin
            rdata_o = 32'(cnt_q);
         end
         if (adr_i == 4'd1) begin
            rdata_o[0 +: NCH] = en_q;
            rdata_o[8 +: NCH] = mask_q;
         end
         if (adr_i == 4'd2) begin
            rdata_o[NCH-1:0] = pend_q;
         end
         if (adr_i == 4'd3) begin
            rdata_o[NCH-1:0] = pend_q & mask_q;
         end
         for (int i = 0; i < NCH; i++) begin
            if (adr_i == 4'(4 + i)) begin
               rdata_o = 32'(cmp_q[i]);
            end
`ifdef SYS_TICK_TIMER_PERIODIC_EN
            if (adr_i == 4'(8 + i)) begin
               rdata_o = 32'(per_q[i]);
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_sys_tick_timer.sv
// Bench for sys_tick_timer with DIV=10: directed register sequences, a reference model and per-cycle compare.
// Latency: model state follows each rising edge; outputs compared on the falling edge.
// Backpressure: not applicable; all waits are cycle-bounded.
module tb_sys_tick_timer;

   localparam int DIV = 10;

   logic        clk, rst_n, sel, wr, rd, tick, irq;
   logic [3:0]  adr;
   logic [31:0] wdata, rdata;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int          m_cyc;
   logic [31:0] m_cnt;
   logic [3:0]  m_en, m_mask, m_pend;
   logic [31:0] m_cmp [4];
   logic [31:0] m_per [4];

   sys_tick_timer #(
      .CLK_FREQ_HZ(10000), .TICK_HZ(1000), .NCH(4), .CNT_W(32)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .wr_i(wr), .rd_i(rd),
      .adr_i(adr), .wdata_i(wdata), .rdata_o(rdata), .tick_o(tick), .irq_o(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: ticks every DIV cycles since reset or last counter write; counter steps on ticks.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc  <= 0;
         m_cnt  <= '0;
         m_en   <= '0;
         m_mask <= '0;
         m_pend <= '0;
         for (int i = 0; i < 4; i++) begin
            m_cmp[i] <= '0;
            m_per[i] <= '0;
         end
      end else begin : upd
         logic        w;
         logic [31:0] nxt;
         logic [3:0]  hit;
         logic [3:0]  p;
         w   = sel && wr;
         hit = '0;
         nxt = m_cnt;
         if (w && adr == 4'd0) begin
            nxt = wdata;
            m_cyc <= 0;
         end else begin
            if ((m_cyc % DIV) == DIV - 1) begin
               nxt = m_cnt + 32'd1;
               for (int i = 0; i < 4; i++)
                  if (m_en[i] && nxt == m_cmp[i]) hit[i] = 1'b1;
            end
            m_cyc <= m_cyc + 1;
         end
         m_cnt <= nxt;
         p = m_pend;
         if (w && adr == 4'd2) p = p & ~wdata[3:0];
         m_pend <= p | hit;
         if (w && adr == 4'd1) begin
            m_en   <= wdata[3:0];
            m_mask <= wdata[11:8];
         end
         for (int i = 0; i < 4; i++) begin
`ifdef SYS_TICK_TIMER_PERIODIC_EN
            if (hit[i] && m_per[i] != 0) m_cmp[i] <= m_cmp[i] + m_per[i];
            if (w && adr == 4'(8 + i)) m_per[i] <= wdata;
`endif
            if (w && adr == 4'(4 + i)) m_cmp[i] <= wdata;
         end
      end
   end

   function automatic logic [31:0] exp_rdata();
      logic [31:0] r;
      r = '0;
      if (sel) begin
         case (adr)
            4'd0: r = m_cnt;
            4'd1: r = {20'd0, m_mask, 4'd0, m_en};
            4'd2: r = {28'd0, m_pend};
            4'd3: r = {28'd0, m_pend & m_mask};
            4'd4, 4'd5, 4'd6, 4'd7: r = m_cmp[adr - 4'd4];
`ifdef SYS_TICK_TIMER_PERIODIC_EN
            4'd8, 4'd9, 4'd10, 4'd11: r = m_per[adr - 4'd8];
`endif
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("tick", {31'd0, tick}, {31'd0, (m_cyc % DIV) == DIV - 1});
         chk("irq", {31'd0, irq}, {31'd0, |(m_pend & m_mask)});
         chk("rdata", rdata, exp_rdata());
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wreg(input logic [3:0] a, input logic [31:0] d);
      sel = 1'b1; wr = 1'b1; adr = a; wdata = d;
      cycle();
      sel = 1'b0; wr = 1'b0; wdata = '0;
   endtask

   task automatic rreg(input logic [3:0] a, output logic [31:0] d);
      sel = 1'b1; rd = 1'b1; adr = a;
      #1;
      d = rdata;
      cycle();
      sel = 1'b0; rd = 1'b0;
   endtask

   task automatic wait_irq(input int maxc, output bit got);
      got = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         cycle();
         if (irq) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   initial begin : stim
      logic [31:0] v;
      bit          got;
      rst_n = 1'b0; sel = 1'b0; wr = 1'b0; rd = 1'b0; adr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tick", {31'd0, tick}, 32'd0);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      rst_n = 1'b1;

      // 1: free run 100 cycles -> 10 ticks
      repeat (100) cycle();
      rreg(4'd0, v); chk("t1_counter", v, 32'd10);
      rreg(4'd2, v); chk("t1_pending", v, 32'd0);
      chk("t1_irq", {31'd0, irq}, 32'd0);

      // 2: compare channel 0 at 5
      wreg(4'd0, 32'd0);
      wreg(4'd4, 32'd5);
      wreg(4'd1, 32'h0101);
      wait_irq(100, got); chk("t2_irq_rise", {31'd0, got}, 32'd1);
      rreg(4'd0, v); chk("t2_counter", v, 32'd5);
      rreg(4'd2, v); chk("t2_pending", v, 32'd1);
      wreg(4'd2, 32'd1);
      chk("t2_irq_clear", {31'd0, irq}, 32'd0);

      // 3: wrap match on channel 1
      wreg(4'd0, 32'hFFFF_FFFF);
      wreg(4'd5, 32'd0);
      wreg(4'd1, 32'h0202);
      wait_irq(30, got); chk("t3_irq", {31'd0, got}, 32'd1);
      rreg(4'd0, v); chk("t3_counter", v, 32'd0);
      rreg(4'd2, v); chk("t3_pending", v, 32'd2);
      wreg(4'd2, 32'd2);

      // 4: W1C on the same edge as a channel-0 match (counter reaches 3 at edge 30 after the write)
      wreg(4'd1, 32'h0101);
      wreg(4'd0, 32'd0);
      wreg(4'd4, 32'd3);
      repeat (28) cycle();
      wreg(4'd2, 32'd1);
      rreg(4'd2, v); chk("t4_pending", v, 32'd1);
      chk("t4_irq", {31'd0, irq}, 32'd1);

      // 5: masked pending, then unmask, then reset mid-count
      wreg(4'd2, 32'hF);
      wreg(4'd1, 32'h0001);
      wreg(4'd0, 32'd0);
      wreg(4'd4, 32'd3);
      repeat (35) cycle();
      rreg(4'd2, v); chk("t5_pending", v, 32'd1);
      rreg(4'd3, v); chk("t5_status", v, 32'd0);
      chk("t5_irq_masked", {31'd0, irq}, 32'd0);
      wreg(4'd1, 32'h0101);
      chk("t5_irq_unmask", {31'd0, irq}, 32'd1);
      for (int i = 0; i < 2 * DIV && !tick; i++) cycle();
      chk("t5_tick_before_rst", {31'd0, tick}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_tick_rst", {31'd0, tick}, 32'd0);
      chk("t5_irq_rst", {31'd0, irq}, 32'd0);
      rreg(4'd0, v); chk("t5_counter_rst", v, 32'd0);
      rreg(4'd1, v); chk("t5_ctrl_rst", v, 32'd0);
      rreg(4'd2, v); chk("t5_pending_rst", v, 32'd0);
      rst_n = 1'b1;
      cycle();

      // 6: periodic re-arm (macro) or one-shot
      wreg(4'd0, 32'd0);
      wreg(4'd8, 32'd3);
      wreg(4'd4, 32'd2);
      wreg(4'd1, 32'h0101);
      wait_irq(40, got); chk("t6_first", {31'd0, got}, 32'd1);
      rreg(4'd0, v); chk("t6_cnt0", v, 32'd2);
      wreg(4'd2, 32'd1);
`ifdef SYS_TICK_TIMER_PERIODIC_EN
      rreg(4'd8, v); chk("t6_period", v, 32'd3);
      rreg(4'd4, v); chk("t6_cmp_rearm", v, 32'd5);
      wait_irq(40, got); chk("t6_second", {31'd0, got}, 32'd1);
      rreg(4'd0, v); chk("t6_cnt1", v, 32'd5);
      wreg(4'd2, 32'd1);
      wait_irq(40, got); chk("t6_third", {31'd0, got}, 32'd1);
      rreg(4'd0, v); chk("t6_cnt2", v, 32'd8);
      wreg(4'd2, 32'd1);
`else
      rreg(4'd8, v); chk("t6_adr8", v, 32'd0);
      wait_irq(80, got); chk("t6_no_rearm", {31'd0, got}, 32'd0);
      rreg(4'd2, v); chk("t6_pending", v, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
